memory_interface: RTL and testbench

//  Memory stage directly downstream of the datapath bus mux: captures BusMuxOut into MAR/MDR.

---
 rtl/memory_interface_pkg.sv | 14 +
 rtl/memory_interface_if.sv | 17 +
 rtl/memory_interface_timeout_counter.sv | 27 ++
 rtl/memory_interface.sv | 128 ++++++++++++
 tb/tb_memory_interface.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/memory_interface_pkg.sv
// Shared types and default widths for the memory stage.
package mem_if_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ADDR_W_DEF  = 9;
  localparam int unsigned TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDone = 2'd2
  } memState_t;

endpackage

// File: rtl/memory_interface_if.sv
// External memory bus: single-word req/ack handshake.
interface memory_interface_if #(
  parameter int unsigned DATA_W = mem_if_pkg::DATA_W_DEF,
  parameter int unsigned ADDR_W = mem_if_pkg::ADDR_W_DEF
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);

endinterface

// File: rtl/memory_interface_timeout_counter.sv
// Counts cycles spent in REQ and flags the last allowed cycle.
module mem_timeout_counter #(
  parameter int unsigned TIMEOUT = mem_if_pkg::TIMEOUT_DEF
) (
  input  logic clock,
  input  logic clear,
  input  logic start,
  input  logic active,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cntQ;

  // Restart on REQ entry, advance once per REQ cycle.
  always_ff @(posedge clock) begin
    if (clear || start) begin
      cntQ <= '0;
    end else if (active) begin
      cntQ <= cntQ + 1'b1;
    end
  end

  assign expired = active && (cntQ == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/memory_interface.sv
// Memory stage: MAR/MDR capture from the bus mux, single-word memory transactions.
// Optional build macro MEM_TIMEOUT_EN adds an abort after TIMEOUT cycles without ack
// and a sticky err flag; without it REQ waits indefinitely and err is 0.
module memory_interface
  import mem_if_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = TIMEOUT_DEF
`endif
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [DATA_W-1:0]   BusMuxOut,
  input  logic                MARin,
  input  logic                MDRin,
  input  logic                Read,
  input  logic                Write,
  memory_interface_if.master  mem,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [DATA_W-1:0]   BusMuxInMDR
);

  memState_t         stateQ, stateD;
  logic [ADDR_W-1:0] marQ;
  logic [DATA_W-1:0] mdrQ;
  logic              weQ;
  logic              startTxn;
  logic              abort;

  // Read has priority over Write when both arrive together.
  assign startTxn = (stateQ == StIdle) && (Read || Write);

`ifdef MEM_TIMEOUT_EN
  logic timeoutHit;
  logic errQ;

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .clear   (clear),
    .start   (startTxn),
    .active  (stateQ == StReq),
    .expired (timeoutHit)
  );

  // An ack on the last allowed cycle still completes normally.
  assign abort = timeoutHit && !mem.ack;

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (clear) begin
      errQ <= 1'b0;
    end else if (abort) begin
      errQ <= 1'b1;
    end
  end

  assign err = errQ;
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (clear) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic; requests outside IDLE are dropped.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: if (Read || Write) stateD = StReq;
      StReq: begin
        if (mem.ack) begin
          stateD = StDone;
        end else if (abort) begin
          stateD = StIdle;
        end
      end
      StDone:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  // MAR/MDR/direction registers; frozen during REQ so the bus stays stable.
  always_ff @(posedge clock) begin
    if (clear) begin
      marQ <= '0;
      mdrQ <= '0;
      weQ  <= 1'b0;
    end else begin
      if (stateQ != StReq && MARin) begin
        marQ <= BusMuxOut[ADDR_W-1:0];
      end
      if (stateQ == StReq && mem.ack && !weQ) begin
        mdrQ <= mem.rdata;
      end else if (stateQ != StReq && MDRin) begin
        mdrQ <= BusMuxOut;
      end
      if (startTxn) begin
        weQ <= !Read;
      end
    end
  end

  // Decoded handshake and status outputs.
  always_comb begin
    mem.req = (stateQ == StReq);
    mem.we  = (stateQ == StReq) && weQ;
    busy    = (stateQ == StReq);
    done    = (stateQ == StDone);
  end

  assign mem.addr    = marQ;
  assign mem.wdata   = mdrQ;
  assign BusMuxInMDR = mdrQ;

endmodule

// File: tb/tb_memory_interface.sv
// Directed bench for memory_interface: cycle table plus timeout/long-wait sequences.
module tb_memory_interface;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, Read, Write;
  logic        busy, done, err;
  logic [31:0] BusMuxInMDR;

  int total = 0;
  int bad   = 0;

  memory_interface_if #(.DATA_W(32), .ADDR_W(9)) memBus ();

  memory_interface #(
    .DATA_W (32),
    .ADDR_W (9)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT (16)
`endif
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .BusMuxOut   (BusMuxOut),
    .MARin       (MARin),
    .MDRin       (MDRin),
    .Read        (Read),
    .Write       (Write),
    .mem         (memBus),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .BusMuxInMDR (BusMuxInMDR)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        clr;
    logic [31:0] bus;
    logic        marIn, mdrIn, rd, wr, ack;
    logic [31:0] rdata;
    logic        eReq, eWe, eBusy, eDone;
    logic [8:0]  eAddr;
    logic [31:0] eMdr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic clr, logic [31:0] bus, logic marIn, logic mdrIn,
                              logic rd, logic wr, logic ack, logic [31:0] rdata,
                              logic eReq, logic eWe, logic eBusy, logic eDone,
                              logic [8:0] eAddr, logic [31:0] eMdr);
    vec_t v;
    v.clr = clr; v.bus = bus; v.marIn = marIn; v.mdrIn = mdrIn;
    v.rd = rd; v.wr = wr; v.ack = ack; v.rdata = rdata;
    v.eReq = eReq; v.eWe = eWe; v.eBusy = eBusy; v.eDone = eDone;
    v.eAddr = eAddr; v.eMdr = eMdr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    clear = 1'b0; BusMuxOut = '0; MARin = 1'b0; MDRin = 1'b0;
    Read = 1'b0; Write = 1'b0; memBus.ack = 1'b0; memBus.rdata = '0;
  endtask

  initial begin
    logic        allReq;
    logic        sawDone;
    int          n;
    logic [31:0] mdrHold;

    idleInputs();
    clear = 1'b1;

    // Reset
    vecs.push_back(mk(1, 32'h0, 0,0,0,0,0, 32'h0,          0,0,0,0, 9'h000, 32'h0));
    vecs.push_back(mk(1, 32'h0, 0,0,0,0,0, 32'h0,          0,0,0,0, 9'h000, 32'h0));
    // Write of 0xDEADBEEF to 0x1A5, ack during the third REQ cycle
    vecs.push_back(mk(0, 32'h0000_01A5, 1,0,0,0,0, 32'h0,  0,0,0,0, 9'h1A5, 32'h0));
    vecs.push_back(mk(0, 32'hDEAD_BEEF, 0,1,0,0,0, 32'h0,  0,0,0,0, 9'h1A5, 32'hDEAD_BEEF));
    vecs.push_back(mk(0, 32'h0, 0,0,0,1,0, 32'h0,          1,1,1,0, 9'h1A5, 32'hDEAD_BEEF));
    vecs.push_back(mk(0, 32'h1111_1111, 1,1,0,0,0, 32'h0,  1,1,1,0, 9'h1A5, 32'hDEAD_BEEF));
    vecs.push_back(mk(0, 32'h0, 0,0,0,0,0, 32'h0,          1,1,1,0, 9'h1A5, 32'hDEAD_BEEF));
    vecs.push_back(mk(0, 32'h0, 0,0,0,0,1, 32'h5555_5555,  0,0,0,1, 9'h1A5, 32'hDEAD_BEEF));
    vecs.push_back(mk(0, 32'h0, 0,0,0,0,0, 32'h0,          0,0,0,0, 9'h1A5, 32'hDEAD_BEEF));
    // Read from 0x010, ack in cycle 2, data visible in cycle 3 despite MDRin
    vecs.push_back(mk(0, 32'h0000_0010, 1,0,0,0,0, 32'h0,  0,0,0,0, 9'h010, 32'hDEAD_BEEF));
    vecs.push_back(mk(0, 32'h0, 0,0,1,0,0, 32'h0,          1,0,1,0, 9'h010, 32'hDEAD_BEEF));
    vecs.push_back(mk(0, 32'h0, 0,0,0,0,0, 32'h0,          1,0,1,0, 9'h010, 32'hDEAD_BEEF));
    vecs.push_back(mk(0, 32'hAAAA_AAAA, 0,1,0,0,1, 32'h1234_5678, 0,0,0,1, 9'h010, 32'h1234_5678));
    vecs.push_back(mk(0, 32'h0, 0,0,0,0,0, 32'h0,          0,0,0,0, 9'h010, 32'h1234_5678));
    // Read+Write together reads; MARin/Write during REQ ignored
    vecs.push_back(mk(0, 32'h0, 0,0,1,1,0, 32'h0,          1,0,1,0, 9'h010, 32'h1234_5678));
    vecs.push_back(mk(0, 32'h0000_00FF, 1,0,0,1,0, 32'h0,  1,0,1,0, 9'h010, 32'h1234_5678));
    vecs.push_back(mk(0, 32'h0, 0,0,0,0,1, 32'hCAFE_F00D,  0,0,0,1, 9'h010, 32'hCAFE_F00D));
    vecs.push_back(mk(0, 32'h0, 0,0,0,1,0, 32'h0,          0,0,0,0, 9'h010, 32'hCAFE_F00D));
    vecs.push_back(mk(0, 32'h0, 0,0,0,0,1, 32'hFFFF_FFFF,  0,0,0,0, 9'h010, 32'hCAFE_F00D));
    vecs.push_back(mk(0, 32'h0000_0123, 1,1,0,0,0, 32'h0,  0,0,0,0, 9'h123, 32'h0000_0123));
    // Clear mid-REQ, then a normal read (address truncated to 9 bits)
    vecs.push_back(mk(0, 32'h0, 0,0,1,0,0, 32'h0,          1,0,1,0, 9'h123, 32'h0000_0123));
    vecs.push_back(mk(1, 32'h0, 0,0,0,0,0, 32'h0,          0,0,0,0, 9'h000, 32'h0));
    vecs.push_back(mk(0, 32'hABCD_0207, 1,0,1,0,0, 32'h0,  1,0,1,0, 9'h007, 32'h0));
    vecs.push_back(mk(0, 32'h0, 0,0,0,0,1, 32'h0BAD_CAFE,  0,0,0,1, 9'h007, 32'h0BAD_CAFE));
    vecs.push_back(mk(0, 32'h0, 0,0,0,0,0, 32'h0,          0,0,0,0, 9'h007, 32'h0BAD_CAFE));

    for (int i = 0; i < vecs.size(); i++) begin
      clear = vecs[i].clr; BusMuxOut = vecs[i].bus; MARin = vecs[i].marIn;
      MDRin = vecs[i].mdrIn; Read = vecs[i].rd; Write = vecs[i].wr;
      memBus.ack = vecs[i].ack; memBus.rdata = vecs[i].rdata;
      step();
      check($sformatf("v%0d.req", i),   {31'b0, memBus.req}, {31'b0, vecs[i].eReq});
      check($sformatf("v%0d.we", i),    {31'b0, memBus.we},  {31'b0, vecs[i].eWe});
      check($sformatf("v%0d.busy", i),  {31'b0, busy},       {31'b0, vecs[i].eBusy});
      check($sformatf("v%0d.done", i),  {31'b0, done},       {31'b0, vecs[i].eDone});
      check($sformatf("v%0d.addr", i),  {23'b0, memBus.addr}, {23'b0, vecs[i].eAddr});
      check($sformatf("v%0d.wdata", i), memBus.wdata,        vecs[i].eMdr);
      check($sformatf("v%0d.mdr", i),   BusMuxInMDR,         vecs[i].eMdr);
      check($sformatf("v%0d.err", i),   {31'b0, err},        32'h0);
    end
    idleInputs();
    step();

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after 16 REQ cycles, sticky err, no done pulse
    mdrHold = BusMuxInMDR;
    Read = 1'b1;
    step();
    Read = 1'b0;
    n = 0;
    sawDone = 1'b0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (done === 1'b1) sawDone = 1'b1;
      step();
    end
    if (done === 1'b1) sawDone = 1'b1;
    check("to.reqCycles", n, 32'd16);
    check("to.err", {31'b0, err}, 32'h1);
    check("to.noDone", {31'b0, sawDone}, 32'h0);
    check("to.req", {31'b0, memBus.req}, 32'h0);
    check("to.mdr", BusMuxInMDR, mdrHold);
    memBus.ack = 1'b1; memBus.rdata = 32'h7777_7777;
    step();
    idleInputs();
    check("to.strayMdr", BusMuxInMDR, mdrHold);
    check("to.strayDone", {31'b0, done}, 32'h0);
    check("to.strayBusy", {31'b0, busy}, 32'h0);
    step();
    check("to.errSticky", {31'b0, err}, 32'h1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("to.errClear", {31'b0, err}, 32'h0);
`else
    // No ack for 40 cycles: REQ must hold without any abort
    Write = 1'b1;
    step();
    Write = 1'b0;
    allReq = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (memBus.req !== 1'b1 || busy !== 1'b1 || memBus.we !== 1'b1) allReq = 1'b0;
      step();
    end
    check("wait.reqHeld", {31'b0, allReq}, 32'h1);
    check("wait.err", {31'b0, err}, 32'h0);
    memBus.ack = 1'b1;
    step();
    memBus.ack = 1'b0;
    check("wait.done", {31'b0, done}, 32'h1);
    check("wait.mdr", BusMuxInMDR, 32'h0BAD_CAFE);
    step();
    check("wait.idle", {31'b0, done | busy}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
